// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a single-entry
// valid/ready output register with frame-error and overrun pulses.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              sync1_q, rx_s_q;
   logic              deliver_q, deliver_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              ferr_q, ferr_d;
   logic              ovr_q, ovr_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         deliver_q <= 1'b0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         sync1_q   <= rx;
         rx_s_q    <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         deliver_q <= deliver_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      deliver_d = 1'b0;
      ferr_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rx_s_q) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end
         StStart: begin
            if (cnt_q == CntHalf) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d = StData;
                  idx_d   = '0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StData: begin
            if (cnt_q == CntLast) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s_q;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = StStop;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StStop: begin
            if (cnt_q == CntLast) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  deliver_d = 1'b1;
                  state_d   = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StBreak: begin
            if (rx_s_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Delivery runs one cycle after the stop sample; shift_q is untouched until the
   // next frame's first data bit, so it is still intact here.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (deliver_q) begin
         if (!valid_q || ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port data_out  output  8  received byte; valid only while valid=1.
REQ-006 SHALL have port valid  output  1  byte available.
REQ-007 SHALL have port ready  input  1  consumer accepts byte when valid&&ready at a rising edge.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse, completed byte dropped because previous byte not yet accepted.
REQ-010 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer; only the second flop output (rx_s) drives downstream logic.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK, plus a bit counter (clog2(CLKS_PER_BIT) bits) and a 3-bit bit index.
REQ-013 IDLE: on rx_s=0, go to START with counter=0; otherwise stay.
REQ-014 START: counter increments each cycle; when counter = CLKS_PER_BIT/2 - 1 (integer divide), sample rx_s: 0 -> DATA with counter=0, bit index=0; 1 -> IDLE (glitch rejected, no flag).
REQ-015 DATA: when counter = CLKS_PER_BIT-1, shift rx_s into bit[bit index] of the shift register, reset counter, increment bit index; after bit index 7 is sampled, go to STOP.
REQ-016 STOP: when counter = CLKS_PER_BIT-1, sample rx_s: 1 -> deliver byte (REQ-018..020), go to IDLE; 0 -> pulse frame_err, discard byte, go to BREAK.
REQ-017 BREAK: stay until rx_s=1, then IDLE; no new start is detected while in BREAK.
REQ-018 Delivery with valid=0 or (valid=1 and ready=1 same cycle): data_out <= shift register, valid=1 from next cycle.
REQ-019 Delivery with valid=1 and ready=0: data_out and valid unchanged, overrun pulses high for exactly one cycle.
REQ-020 Accept (valid&&ready, no simultaneous delivery): valid=0 next cycle; data_out holds its last value.
REQ-021 data_out SHALL be stable while valid=1 and not accepted.
REQ-022 Latency: valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the clk edge that first samples rx=0 at the synchronizer input (±0).
REQ-023 A new start bit SHALL be detectable on the cycle after STOP -> IDLE; back-to-back frames with no idle gap SHALL be received without loss.
REQ-024 ready SHALL be ignored while valid=0.

Reset
REQ-025 While rstn=0 at a rising edge: state=IDLE, counter=0, bit index=0, both sync flops=1, data_out=8'h00, valid=0, frame_err=0, overrun=0, busy=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no valid, frame_err or overrun pulse; after release the block waits in IDLE for a fresh falling edge.
REQ-027 Outputs SHALL take reset values on the first edge with rstn=0; no dependence on initial blocks.

Verification (CLKS_PER_BIT=8 unless stated)
REQ-028 Send 8'hA5 with a valid stop bit, ready held 1 -> valid high exactly one cycle, data_out=8'hA5, first valid at cycle 2+4+72+1 after start edge, frame_err=overrun=0.
REQ-029 Send 8'h3C then 8'hC3 back-to-back, ready=0 until both frames end -> data_out=8'h3C held, valid stays 1, overrun pulses once at end of second frame; raise ready -> valid falls next cycle.
REQ-030 Send 8'h55 with stop bit driven 0, then rx held 0 for 20 bit times, then 1 -> frame_err one pulse, valid never rises, busy stays 1 until rx returns high, then IDLE.
REQ-031 Drive rx low for 2 cycles then high -> START rejects glitch, returns to IDLE, no outputs change.
REQ-032 Assert rstn=0 during bit 4 of a frame, release, send 8'h81 -> only 8'h81 delivered, no flags.
REQ-033 CLKS_PER_BIT=104, send 8'hFF then 8'h00 with ready tied 1 -> two deliveries in order, data correct, no flags.
